// File: rtl/fpu_pkg.sv
// Shared FPU definitions: funct codes, canonical NaN,
// default writeback depth and the buffered result bundle.
package fpu_pkg;

    localparam logic [2:0] FN_FLE  = 3'b000;
    localparam logic [2:0] FN_FLT  = 3'b001;
    localparam logic [2:0] FN_FEQ  = 3'b010;
    localparam logic [2:0] FN_FMIN = 3'b100;
    localparam logic [2:0] FN_FMAX = 3'b101;

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    localparam int DEFAULT_DEPTH = 2;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        nv;
    } wb_t;

endpackage

// File: rtl/fpu_wb_fifo.sv
// Small valid/ready result buffer; output is zero while empty
// so nothing stale is visible after reset.
module fpu_wb_fifo #(
    parameter int WIDTH = 38,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push;
    logic             pop;

    assign in_ready  = count < (AW+1)'(DEPTH);
    assign out_valid = count != '0;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpu_cmp_writeback.sv
// FP compare / min / max result stage with buffered writeback
// and a sticky invalid-operation flag.
module fpu_cmp_writeback
    import fpu_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        io_in_valid,
    output logic        io_in_ready,
    input  logic [31:0] io_in_a,
    input  logic [31:0] io_in_b,
    input  logic [2:0]  io_in_funct,
    input  logic [4:0]  io_in_rd,
    input  logic        io_a_hi_b,
    input  logic        io_a_equal_b,
    output logic        io_out_valid,
    input  logic        io_out_ready,
    output logic [31:0] io_out_data,
    output logic [4:0]  io_out_rd,
    output logic        io_out_nv,
    output logic        io_fflags_nv,
    input  logic        io_fflags_clear
);

    logic        a_nan, b_nan, a_snan, b_snan;
    logic        any_nan, any_snan, lt, acc;
    logic [31:0] fmin_v, fmax_v;
    wb_t         res, head;

    assign a_nan    = (io_in_a[30:23] == 8'hFF) && (io_in_a[22:0] != '0);
    assign b_nan    = (io_in_b[30:23] == 8'hFF) && (io_in_b[22:0] != '0);
    assign a_snan   = a_nan & ~io_in_a[22];
    assign b_snan   = b_nan & ~io_in_b[22];
    assign any_nan  = a_nan | b_nan;
    assign any_snan = a_snan | b_snan;
    assign lt       = ~io_a_hi_b & ~io_a_equal_b;

    always_comb begin
        fmin_v = lt ? io_in_a : io_in_b;
        fmax_v = lt ? io_in_b : io_in_a;
        if (a_nan && b_nan) begin
            fmin_v = CANON_NAN;
            fmax_v = CANON_NAN;
        end else if (a_nan) begin
            fmin_v = io_in_b;
            fmax_v = io_in_b;
        end else if (b_nan) begin
            fmin_v = io_in_a;
            fmax_v = io_in_a;
        end else if (io_a_equal_b && (io_in_a[31] != io_in_b[31])) begin
            // +0 vs -0: pick by sign
            fmin_v = io_in_a[31] ? io_in_a : io_in_b;
            fmax_v = io_in_a[31] ? io_in_b : io_in_a;
        end
    end

    always_comb begin
        res    = '0;
        res.rd = io_in_rd;
        unique case (1'b1)
            io_in_funct == FN_FLE: begin
                res.data = {31'b0, (lt | io_a_equal_b) & ~any_nan};
                res.nv   = any_nan;
            end
            io_in_funct == FN_FLT: begin
                res.data = {31'b0, lt & ~any_nan};
                res.nv   = any_nan;
            end
            io_in_funct == FN_FEQ: begin
                res.data = {31'b0, io_a_equal_b & ~any_nan};
                res.nv   = any_snan;
            end
            io_in_funct == FN_FMIN: begin
                res.data = fmin_v;
                res.nv   = any_snan;
            end
            io_in_funct == FN_FMAX: begin
                res.data = fmax_v;
                res.nv   = any_snan;
            end
            default: begin
                res.data = '0;
                res.nv   = 1'b0;
            end
        endcase
    end

    fpu_wb_fifo #(
        .WIDTH($bits(wb_t)),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clock),
        .rst_n    (reset_n),
        .in_valid (io_in_valid),
        .in_ready (io_in_ready),
        .in_data  (res),
        .out_valid(io_out_valid),
        .out_ready(io_out_ready),
        .out_data (head)
    );

    assign io_out_data = head.data;
    assign io_out_rd   = head.rd;
    assign io_out_nv   = head.nv;
    assign acc         = io_in_valid & io_in_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            io_fflags_nv <= 1'b0;
        end else if (acc && res.nv) begin
            io_fflags_nv <= 1'b1;
        end else if (io_fflags_clear) begin
            io_fflags_nv <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fpu_cmp_writeback.sv
// Directed and random checks of fpu_cmp_writeback against
// a value-level reference model with a result queue.
module tb_fpu_cmp_writeback;

    localparam int DEPTH = 2;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic [2:0]  funct;
    logic [4:0]  rd;
    logic        hi, eq;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic        out_nv;
    logic        fflags_nv;
    logic        fclear;

    int total = 0;
    int bad   = 0;

    logic [37:0] q[$];
    logic        fl;

    always #5 clock = ~clock;

    fpu_cmp_writeback #(.DEPTH(DEPTH)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .io_in_valid    (in_valid),
        .io_in_ready    (in_ready),
        .io_in_a        (a),
        .io_in_b        (b),
        .io_in_funct    (funct),
        .io_in_rd       (rd),
        .io_a_hi_b      (hi),
        .io_a_equal_b   (eq),
        .io_out_valid   (out_valid),
        .io_out_ready   (out_ready),
        .io_out_data    (out_data),
        .io_out_rd      (out_rd),
        .io_out_nv      (out_nv),
        .io_fflags_nv   (fflags_nv),
        .io_fflags_clear(fclear)
    );

    // Signed magnitude ordering: +0 and -0 map to the same key
    function automatic longint ord(input logic [31:0] x);
        longint m;
        m = longint'(x[30:0]);
        return x[31] ? -m : m;
    endfunction

    function automatic bit is_nan(input logic [31:0] x);
        return x[30:23] == 8'hFF && x[22:0] != 0;
    endfunction

    function automatic bit is_snan(input logic [31:0] x);
        return is_nan(x) && !x[22];
    endfunction

    assign hi = ord(a) > ord(b);
    assign eq = ord(a) == ord(b);

    function automatic logic [37:0] model(
        input logic [31:0] x, input logic [31:0] y,
        input logic [2:0] f, input logic [4:0] t
    );
        bit nx, ny, sn, cmp;
        logic [31:0] d;
        bit v;
        nx = is_nan(x);
        ny = is_nan(y);
        sn = is_snan(x) || is_snan(y);
        d = 0;
        v = 0;
        case (f)
            3'd0: begin cmp = ord(x) <= ord(y); d = {31'b0, cmp && !nx && !ny}; v = nx || ny; end
            3'd1: begin cmp = ord(x) <  ord(y); d = {31'b0, cmp && !nx && !ny}; v = nx || ny; end
            3'd2: begin cmp = ord(x) == ord(y); d = {31'b0, cmp && !nx && !ny}; v = sn; end
            3'd4, 3'd5: begin
                v = sn;
                if (nx && ny) d = 32'h7FC00000;
                else if (nx) d = y;
                else if (ny) d = x;
                else if (ord(x) < ord(y)) d = (f == 3'd4) ? x : y;
                else if (ord(y) < ord(x)) d = (f == 3'd4) ? y : x;
                else if (f == 3'd4) d = x[31] ? x : y;
                else d = x[31] ? y : x;
            end
            default: begin d = 0; v = 0; end
        endcase
        return {d, t, v};
    endfunction

    task automatic check(input string tag, input logic [37:0] obs, input logic [37:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checks outputs against the model, then advances one clock
    task automatic step();
        bit acc, pp;
        logic [37:0] e;
        #1;
        check("in_ready", 38'(in_ready), 38'(q.size() < DEPTH));
        check("out_valid", 38'(out_valid), 38'(q.size() != 0));
        if (q.size() != 0) check("out_bundle", {out_data, out_rd, out_nv}, q[0]);
        check("fflags_nv", 38'(fflags_nv), 38'(fl));
        acc = in_valid && (q.size() < DEPTH);
        pp  = out_ready && (q.size() != 0);
        e   = model(a, b, funct, rd);
        @(posedge clock);
        if (pp) void'(q.pop_front());
        if (acc) q.push_back(e);
        if (acc && e[0]) fl = 1'b1;
        else if (fclear) fl = 1'b0;
        @(negedge clock);
    endtask

    task automatic drive(input logic [31:0] x, input logic [31:0] y,
                         input logic [2:0] f, input logic [4:0] t);
        in_valid = 1'b1;
        a = x; b = y; funct = f; rd = t;
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'h7FC0_0000 | ($urandom & 32'h803F_FFFF);
            3: return 32'h7F80_0001 | ($urandom & 32'h801F_FFFF);
            4: return $urandom_range(0, 1) ? 32'h7F80_0000 : 32'hFF80_0000;
            5: return {$urandom_range(0, 1) == 1, 31'h3F80_0000 + 31'($urandom_range(0, 3))};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit done;
        reset_n = 1'b0;
        in_valid = 0; a = 0; b = 0; funct = 0; rd = 0;
        out_ready = 0; fclear = 0; fl = 0;
        #1;
        check("rst_in_ready", 38'(in_ready), 38'd1);
        check("rst_out_valid", 38'(out_valid), 38'd0);
        check("rst_out", {out_data, out_rd, out_nv}, 38'd0);
        check("rst_fflags", 38'(fflags_nv), 38'd0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        out_ready = 1'b1;

        drive(32'h3F800000, 32'h40000000, 3'b001, 5'd1);
        step();
        in_valid = 0;
        #1;
        check("flt_data", 38'(out_data), 38'd1);
        check("flt_nv", 38'(out_nv), 38'd0);
        step();

        drive(32'h7F800001, 32'h3F800000, 3'b010, 5'd2);
        step();
        in_valid = 0;
        #1;
        check("feq_snan", {out_data, out_nv}, {32'd0, 1'b1});
        step();
        step();
        step();
        check("fflags_sticky", 38'(fflags_nv), 38'd1);
        fclear = 1;
        step();
        fclear = 0;
        check("fflags_clear", 38'(fflags_nv), 38'd0);

        drive(32'h00000000, 32'h80000000, 3'b100, 5'd3);
        step();
        drive(32'h00000000, 32'h80000000, 3'b101, 5'd4);
        #1;
        check("fmin_zero", 38'(out_data), 38'(32'h80000000));
        step();
        drive(32'h7FC00000, 32'h40400000, 3'b101, 5'd5);
        #1;
        check("fmax_zero", 38'(out_data), 38'(32'h00000000));
        step();
        drive(32'h7FC00000, 32'h7FC00000, 3'b101, 5'd6);
        #1;
        check("fmax_qnan", {out_data, out_nv}, {32'h40400000, 1'b0});
        step();
        in_valid = 0;
        #1;
        check("fmax_2nan", 38'(out_data), 38'(32'h7FC00000));
        step();

        // backpressure: two accepts then stall
        out_ready = 0;
        drive(32'h3F800000, 32'h40000000, 3'b000, 5'd7);
        step();
        drive(32'h40000000, 32'h3F800000, 3'b001, 5'd8);
        step();
        drive(32'hC0000000, 32'h3F800000, 3'b100, 5'd9);
        step();
        check("full_in_ready", 38'(in_ready), 38'd0);
        out_ready = 1;
        done = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            done = q.size() < DEPTH;
            step();
        end
        check("third_accepted", 38'(done), 38'd1);
        in_valid = 0;
        for (int i = 0; i < 4; i++) step();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid = $urandom_range(0, 3) != 0;
            a = rnd_op();
            b = $urandom_range(0, 4) == 0 ? a ^ 32'h80000000 : rnd_op();
            funct = 3'($urandom_range(0, 7));
            rd = 5'($urandom);
            out_ready = $urandom_range(0, 2) != 0;
            fclear = $urandom_range(0, 9) == 0;
            step();
        end
        in_valid = 0; fclear = 0; out_ready = 1;
        for (int i = 0; i < 4; i++) step();

        // reset with two entries buffered and NV set
        out_ready = 0;
        drive(32'h7F800001, 32'h3F800000, 3'b000, 5'd10);
        step();
        drive(32'h3F800000, 32'h40000000, 3'b001, 5'd11);
        step();
        in_valid = 0;
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_mid_valid", 38'(out_valid), 38'd0);
        check("rst_mid_fflags", 38'(fflags_nv), 38'd0);
        check("rst_mid_in_ready", 38'(in_ready), 38'd1);
        check("rst_mid_out", {out_data, out_rd, out_nv}, 38'd0);
        q.delete();
        fl = 0;
        @(negedge clock);
        reset_n = 1'b1;
        out_ready = 1;
        for (int i = 0; i < 3; i++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpu_cmp_writeback.md
FPU_CMP_WRITEBACK -- requirements
Module: fpu_cmp_writeback

Interface
REQ-001 SHALL have parameter DEPTH, default 2, giving the number of output buffer entries (power of two, >=2).
REQ-002 SHALL have port clock  in  1  sole clock, rising edge.
REQ-003 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port io_in_valid  in  1  operation offered.
REQ-005 SHALL have port io_in_ready  out  1  operation accepted when high with io_in_valid.
REQ-006 SHALL have port io_in_a  in  32  IEEE-754 single operand A, the same value driven to the comparator.
REQ-007 SHALL have port io_in_b  in  32  operand B, the same value driven to the comparator.
REQ-008 SHALL have port io_in_funct  in  3  operation: 000 FLE, 001 FLT, 010 FEQ, 100 FMIN, 101 FMAX; other codes yield data 0 and nv 0.
REQ-009 SHALL have port io_in_rd  in  5  destination tag, passed through.
REQ-010 SHALL have port io_a_hi_b  in  1  comparator result: A > B, valid only when io_a_equal_b=0.
REQ-011 SHALL have port io_a_equal_b  in  1  comparator result: A == B, with +0 == -0.
REQ-012 SHALL have port io_out_valid  out  1  result available.
REQ-013 SHALL have port io_out_ready  in  1  consumer takes the result.
REQ-014 SHALL have port io_out_data  out  32  result: 0/1 for compares, operand or canonical NaN for FMIN/FMAX.
REQ-015 SHALL have port io_out_rd  out  5  tag of the result.
REQ-016 SHALL have port io_out_nv  out  1  invalid-operation flag of the result.
REQ-017 SHALL have port io_fflags_nv  out  1  sticky accumulated NV flag.
REQ-018 SHALL have port io_fflags_clear  in  1  clears the sticky NV flag.

Function
REQ-019 SHALL treat an operand as NaN when exp==0xFF and mant!=0, and as sNaN when it is NaN and mant[22]==0.
REQ-020 SHALL compute lt = ~io_a_hi_b & ~io_a_equal_b; FLT=lt, FLE=lt|io_a_equal_b, FEQ=io_a_equal_b, each forced to 0 if either operand is NaN.
REQ-021 SHALL set nv for FLT/FLE if either operand is NaN, for FEQ/FMIN/FMAX only if either operand is sNaN.
REQ-022 SHALL return 0x7FC00000 for FMIN/FMAX when both operands are NaN, and the non-NaN operand when exactly one is NaN.
REQ-023 SHALL, for FMIN/FMAX with equal operands of differing sign (±0), return the operand with sign=1 for FMIN and sign=0 for FMAX.
REQ-024 SHALL otherwise return lt?A:B for FMIN and lt?B:A for FMAX.
REQ-025 SHALL accept an operation on a rising edge with io_in_valid & io_in_ready, capturing the computed result, rd and nv into the FIFO.
REQ-026 SHALL present an accepted result on io_out_* at the earliest one cycle after acceptance; there is no combinational path from the inputs to io_out_*.
REQ-027 SHALL drive io_in_ready = (count < DEPTH), independent of io_out_ready; a push is not allowed when the FIFO is full, even if a pop occurs in the same cycle.
REQ-028 SHALL drive io_out_valid = (count > 0) and show the head entry; an entry pops on io_out_valid & io_out_ready.
REQ-029 SHALL, on a simultaneous push and pop, keep count unchanged and preserve order.
REQ-030 SHALL wrap the read and write pointers modulo DEPTH.
REQ-031 SHALL set io_fflags_nv on an accepted operation with nv=1 and clear it on io_fflags_clear; when both occur in the same cycle, set wins.
REQ-032 SHALL hold io_out_* stable while io_out_valid=1 and io_out_ready=0.

Reset
REQ-033 SHALL, when reset_n is low, immediately drive io_out_valid=0, count=0, pointers=0 and io_fflags_nv=0, and hold io_in_ready=1; io_out_data/rd/nv SHALL read 0.
REQ-034 SHALL discard buffered entries when reset is asserted mid-operation; no partial output after reset_n releases.

Structure
REQ-035 SHALL take the funct codes, the canonical NaN constant 0x7FC00000 and the default DEPTH from the shared package fpu_pkg.
REQ-036 SHALL implement the buffer as sub-module fpu_wb_fifo (parameterised width/DEPTH, valid/ready on both sides); the result logic stays in the top level.

Verification
REQ-037 SHALL cover: FLT A=0x3F800000, B=0x40000000, hi=0, eq=0 -> next cycle io_out_data=1, io_out_nv=0.
REQ-038 SHALL cover: FEQ A=0x7F800001 (sNaN), B=0x3F800000 -> io_out_data=0, io_out_nv=1, io_fflags_nv=1 and staying 1 until io_fflags_clear.
REQ-039 SHALL cover: FMIN A=0x00000000, B=0x80000000, eq=1 -> 0x80000000; FMAX on the same operands -> 0x00000000.
REQ-040 SHALL cover: FMAX A=0x7FC00000, B=0x40400000 -> 0x40400000 with nv=0; both operands 0x7FC00000 -> 0x7FC00000.
REQ-041 SHALL cover: io_out_ready=0 with 3 back-to-back ops -> io_in_ready=0 after 2 accepts; after releasing io_out_ready, the results drain in order and the third op is accepted.
REQ-042 SHALL cover: reset_n pulled low with 2 entries buffered -> io_out_valid=0 and io_fflags_nv=0 without waiting for a clock edge, and no stale output after release.
